dmg_timer: RTL

DMG_TIMER -- requirements
Module: dmg_timer

---
 rtl/dmg_pkg.sv | 14 +
 rtl/dmg_divider.sv | 16 +
 rtl/dmg_timer.sv | 75 +++++++
 3 files changed

// File: rtl/dmg_pkg.sv
// dmg_pkg: shared rate-select encoding and overflow-delay default for the DMG timer
package dmg_pkg;
  typedef enum logic [1:0] {
    RATE_4K   = 2'b00,
    RATE_256K = 2'b01,
    RATE_64K  = 2'b10,
    RATE_16K  = 2'b11
  } rate_e;
  localparam int OVF_DELAY_DEFAULT = 4;
  // Divider bit whose falling edge clocks TIMA for a given rate select
  function automatic logic [3:0] rate_bit(input rate_e r);
    return r == RATE_256K ? 4'd3 : r == RATE_64K ? 4'd5 : r == RATE_16K ? 4'd7 : 4'd9;
  endfunction
endpackage

// File: rtl/dmg_divider.sv
// dmg_divider: free-running 16-bit divider with synchronous clear
module dmg_divider (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clr,
  output logic [15:0] cnt
);
  logic [15:0] cnt_q, cnt_d;
  // Clear takes priority over the increment
  always_comb cnt_d = clr ? 16'h0000 : cnt_q + 16'h0001;
  // Divider register
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) cnt_q <= 16'h0000;
    else         cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/dmg_timer.sv
// dmg_timer: DMG DIV/TIMA/TMA/TAC timer with delayed TMA reload and interrupt pulse
module dmg_timer
  import dmg_pkg::*;
#(
  parameter int OVF_DELAY = OVF_DELAY_DEFAULT
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       div_wr,
  input  logic       tima_wr,
  input  logic       tma_wr,
  input  logic       tac_wr,
  input  logic [7:0] wdata,
  output logic [7:0] div,
  output logic [7:0] tima,
  output logic [7:0] tma,
  output logic [2:0] tac,
  output logic       irq
);
  // A zero delay would never reach the reload clock, so the window is at least one clock
  localparam logic [7:0] OVF_LD = 8'(OVF_DELAY < 1 ? 1 : OVF_DELAY);
  logic [15:0] div_cnt;
  logic [7:0]  tima_q, tima_d, tma_q, tma_d, ovf_q, ovf_d;
  logic [2:0]  tac_q, tac_d;
  logic        tick_q, tick_d, irq_q, irq_d, fall, reload;
  dmg_divider u_div (
    .clk    (clk),
    .nreset (nreset),
    .clr    (div_wr),
    .cnt    (div_cnt)
  );
  // Tick edge detection, register writes and the overflow window countdown
  always_comb begin
    tick_d = tac_q[2] & div_cnt[rate_bit(rate_e'(tac_q[1:0]))];
    fall   = tick_q & ~tick_d;
    tac_d  = tac_wr ? wdata[2:0] : tac_q;
    tma_d  = tma_wr ? wdata : tma_q;
    reload = ovf_q == 8'd1;
    ovf_d  = ovf_q == 8'd0 ? 8'd0 : ovf_q - 8'd1;
    tima_d = tima_q;
    irq_d  = 1'b0;
    if (reload) begin
      tima_d = tma_d;
      irq_d  = 1'b1;
    end else if (tima_wr) begin
      tima_d = wdata;
      ovf_d  = 8'd0;
    end else if (fall) begin
      tima_d = tima_q + 8'd1;
      if (tima_q == 8'hFF) ovf_d = OVF_LD;
    end
  end
  // Timer state registers
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      tima_q <= 8'h00;
      tma_q  <= 8'h00;
      tac_q  <= 3'b000;
      tick_q <= 1'b0;
      irq_q  <= 1'b0;
      ovf_q  <= 8'h00;
    end else begin
      tima_q <= tima_d;
      tma_q  <= tma_d;
      tac_q  <= tac_d;
      tick_q <= tick_d;
      irq_q  <= irq_d;
      ovf_q  <= ovf_d;
    end
  assign div  = div_cnt[15:8];
  assign tima = tima_q;
  assign tma  = tma_q;
  assign tac  = tac_q;
  assign irq  = irq_q;
endmodule
